alu_seq: RTL and testbench

Registered, parametrised successor to the 6502 combinational ALU. It accepts one operation per start/ready handshake and supports binary ADD/SUB, logic ops and rotate-through-carry shifts. It adds a multi-cycle decimal (BCD) mode for ADD/SUB, processed one nibble per cycle. It sits between the control unit and the register file, and its done pulse tells the sequencer that the result and flags are valid.

---
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered 6502-style ALU: one operation per start/ready handshake, binary ops in one
// cycle, BCD ADD/SUB one nibble per cycle (LSB first).

module alu_seq_bcd_digit (
  input  logic       sub,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  logic [4:0] s;
  logic [5:0] df;
  logic       gt, neg;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    df   = {2'b0, a} - {2'b0, b} - {5'b0, ~cin};
    gt   = s > 5'd9;
    neg  = df[5];
    d    = s[3:0];
    cout = gt;
    if (sub) begin
      d    = neg ? df[3:0] + 4'd10 : df[3:0];
      cout = ~neg;
    end else if (gt) begin
      d    = s[3:0] + 4'd6;
    end
  end
endmodule

module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [2:0]            alu_control,
  input  logic                  decimal,
  input  logic [DATA_WIDTH-1:0] alu_AI,
  input  logic [DATA_WIDTH-1:0] alu_BI,
  input  logic                  alu_carry_in,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] alu_Y,
  output logic                  alu_carry_out,
  output logic                  alu_overflow,
  output logic                  alu_zero,
  output logic                  alu_negative
);
  localparam int W   = DATA_WIDTH;
  localparam int NIB = W / 4;
  localparam int CW  = $clog2(NIB + 1);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SR  = 3'd5, OP_SL  = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, DEC} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_r, b_r, acc, acc_next;
  logic [2:0]      op_r;
  logic            cin_r, dc;
  logic [CW-1:0]   nib;
  logic            accept, go_dec, last_nib;

  logic [W-1:0]    b_eff, bin_y;
  logic [W:0]      sum;
  logic            bin_c, bin_v;
  logic [3:0]      dig;
  logic            dig_c;

  assign accept   = start && ready;
  assign go_dec   = DECIMAL_EN && decimal && (alu_control[2:1] == 2'b00);
  assign last_nib = (nib == CW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = go_dec ? DEC : EXEC;
      EXEC:    state_next = IDLE;
      DEC:     if (last_nib) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SUB adds the inverted operand; V compares against the operand actually added.
  always_comb begin
    b_eff = (op_r == OP_SUB) ? ~b_r : b_r;
    sum   = {1'b0, a_r} + {1'b0, b_eff} + {{W{1'b0}}, cin_r};
    bin_y = a_r;
    bin_c = 1'b0;
    bin_v = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        bin_y = sum[W-1:0];
        bin_c = sum[W];
        bin_v = (a_r[W-1] == b_eff[W-1]) && (sum[W-1] != a_r[W-1]);
      end
      OP_AND:  bin_y = a_r & b_r;
      OP_OR:   bin_y = a_r | b_r;
      OP_XOR:  bin_y = a_r ^ b_r;
      OP_SR: begin
        bin_y = {cin_r, a_r[W-1:1]};
        bin_c = a_r[0];
      end
      OP_SL: begin
        bin_y = {a_r[W-2:0], cin_r};
        bin_c = a_r[W-1];
      end
      default: bin_y = a_r;
    endcase
  end

  alu_seq_bcd_digit u_digit (
    .sub  (op_r[0]),
    .a    (a_r[3:0]),
    .b    (b_r[3:0]),
    .cin  (dc),
    .d    (dig),
    .cout (dig_c)
  );

  // Operands shift right under the digit unit; digits shift in from the top.
  assign acc_next = {dig, acc[W-1:4]};

  // Flags are registered with the result so reset can clear all of them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready         <= 1'b1;
      done          <= 1'b0;
      alu_Y         <= '0;
      alu_carry_out <= 1'b0;
      alu_overflow  <= 1'b0;
      alu_zero      <= 1'b0;
      alu_negative  <= 1'b0;
      a_r           <= '0;
      b_r           <= '0;
      acc           <= '0;
      op_r          <= '0;
      cin_r         <= 1'b0;
      dc            <= 1'b0;
      nib           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          a_r   <= alu_AI;
          b_r   <= alu_BI;
          op_r  <= alu_control;
          cin_r <= alu_carry_in;
          dc    <= alu_carry_in;
          acc   <= '0;
          nib   <= '0;
          ready <= 1'b0;
        end
        EXEC: begin
          alu_Y         <= bin_y;
          alu_carry_out <= bin_c;
          alu_overflow  <= bin_v;
          alu_zero      <= (bin_y == '0);
          alu_negative  <= bin_y[W-1];
          done          <= 1'b1;
          ready         <= 1'b1;
        end
        DEC: begin
          a_r <= a_r >> 4;
          b_r <= b_r >> 4;
          acc <= acc_next;
          dc  <= dig_c;
          nib <= nib + CW'(1);
          if (last_nib) begin
            alu_Y         <= acc_next;
            alu_carry_out <= dig_c;
            alu_overflow  <= 1'b0;
            alu_zero      <= (acc_next == '0);
            alu_negative  <= acc_next[W-1];
            done          <= 1'b1;
            ready         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (W8 decimal, W16 decimal, W16 binary-only) checked
// every cycle against an arithmetic model, plus directed literal checks.
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [2:0]       start_v, dec_v, cin_v;
  logic [2:0][2:0]  op_v;
  logic [2:0][15:0] a_v, b_v;
  logic [2:0]       ready_v, done_v, c_v, v_v, z_v, n_v;
  logic [7:0]       y0;
  logic [15:0]      y1, y2;

  int compared = 0, mismatched = 0;

  alu_seq #(.DATA_WIDTH(8), .DECIMAL_EN(1'b1)) u0 (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .alu_control(op_v[0]), .decimal(dec_v[0]),
    .alu_AI(a_v[0][7:0]), .alu_BI(b_v[0][7:0]), .alu_carry_in(cin_v[0]), .ready(ready_v[0]),
    .done(done_v[0]), .alu_Y(y0), .alu_carry_out(c_v[0]), .alu_overflow(v_v[0]),
    .alu_zero(z_v[0]), .alu_negative(n_v[0]));

  alu_seq #(.DATA_WIDTH(16), .DECIMAL_EN(1'b1)) u1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .alu_control(op_v[1]), .decimal(dec_v[1]),
    .alu_AI(a_v[1]), .alu_BI(b_v[1]), .alu_carry_in(cin_v[1]), .ready(ready_v[1]),
    .done(done_v[1]), .alu_Y(y1), .alu_carry_out(c_v[1]), .alu_overflow(v_v[1]),
    .alu_zero(z_v[1]), .alu_negative(n_v[1]));

  alu_seq #(.DATA_WIDTH(16), .DECIMAL_EN(1'b0)) u2 (
    .clk(clk), .resetn(resetn), .start(start_v[2]), .alu_control(op_v[2]), .decimal(dec_v[2]),
    .alu_AI(a_v[2]), .alu_BI(b_v[2]), .alu_carry_in(cin_v[2]), .ready(ready_v[2]),
    .done(done_v[2]), .alu_Y(y2), .alu_carry_out(c_v[2]), .alu_overflow(v_v[2]),
    .alu_zero(z_v[2]), .alu_negative(n_v[2]));

  int wk[3]  = '{8, 16, 16};
  bit dek[3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic [15:0] y_of(input int k);
    if (k == 0) return {8'h00, y0};
    if (k == 1) return y1;
    return y2;
  endfunction

  function automatic longint sx(input longint x, input int w);
    return (x >= (64'sd1 <<< (w - 1))) ? x - (64'sd1 <<< w) : x;
  endfunction

  // Result of one operation from the arithmetic rules; lat = cycles from accept to done.
  function automatic void model(input int w, input bit de, input logic [2:0] op, input bit dec,
                                input logic [15:0] ai, input logic [15:0] bi, input bit cin,
                                output logic [15:0] y, output bit c, output bit v, output int lat);
    longint mask, a, b, u, r, bb;
    int ca, d, x, z;
    mask = (64'sd1 <<< w) - 1;
    a = longint'(ai) & mask;
    b = longint'(bi) & mask;
    lat = 1; c = 1'b0; v = 1'b0; u = a;
    if (op <= 3'd1 && de && dec) begin
      lat = w / 4; ca = int'(cin); u = 0;
      for (int i = 0; i < w / 4; i++) begin
        x = int'((a >> (4 * i)) & 15);
        z = int'((b >> (4 * i)) & 15);
        if (op == 3'd0) begin
          d = x + z + ca;
          if (d > 9) begin d = d + 6; ca = 1; end else ca = 0;
        end else begin
          d = x - z - (1 - ca);
          if (d < 0) begin d = d + 10; ca = 0; end else ca = 1;
        end
        u = u | (longint'(d & 15) << (4 * i));
      end
      c = ca[0];
    end else begin
      case (op)
        3'd0, 3'd1: begin
          bb = (op == 3'd0) ? b : (~b & mask);
          u  = a + bb + longint'(cin);
          c  = u[w];
          r  = sx(a, w) + sx(bb, w) + longint'(cin);
          v  = (r > (64'sd1 <<< (w - 1)) - 1) || (r < -(64'sd1 <<< (w - 1)));
        end
        3'd2: u = a & b;
        3'd3: u = a | b;
        3'd4: u = a ^ b;
        3'd5: begin u = (longint'(cin) << (w - 1)) | (a >> 1); c = a[0]; end
        3'd6: begin u = (a << 1) | longint'(cin); c = a[w-1]; end
        default: u = a;
      endcase
    end
    y = 16'(u & mask);
  endfunction

  // Per-instance model state, advanced on every rising edge.
  bit          armed = 1'b0;
  bit          busy[3], mready[3], mdone[3], mc[3], mv[3], mz[3], mn[3], pc[3], pv[3];
  int          cnt[3];
  logic [15:0] my[3], py[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        busy[k] = 1'b0; mready[k] = 1'b1; mdone[k] = 1'b0;
        my[k] = '0; mc[k] = 1'b0; mv[k] = 1'b0; mz[k] = 1'b0; mn[k] = 1'b0;
      end else begin
        mdone[k] = 1'b0;
        if (busy[k]) begin
          cnt[k] = cnt[k] - 1;
          if (cnt[k] == 0) begin
            busy[k] = 1'b0; mready[k] = 1'b1; mdone[k] = 1'b1;
            my[k] = py[k]; mc[k] = pc[k]; mv[k] = pv[k];
            mz[k] = (py[k] == 16'h0); mn[k] = py[k][wk[k]-1];
          end
        end else if (start_v[k]) begin
          model(wk[k], dek[k], op_v[k], dec_v[k], a_v[k], b_v[k], cin_v[k], py[k], pc[k], pv[k], cnt[k]);
          busy[k] = 1'b1; mready[k] = 1'b0;
        end
      end
    end
    if (!resetn) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        compared++;
        if (ready_v[k] !== mready[k] || done_v[k] !== mdone[k] || y_of(k) !== my[k] ||
            c_v[k] !== mc[k] || v_v[k] !== mv[k] || z_v[k] !== mz[k] || n_v[k] !== mn[k]) begin
          mismatched++;
          $display("FAIL model_cmp dut%0d t=%0t got rdy=%b done=%b y=%h c=%b v=%b z=%b n=%b, expected rdy=%b done=%b y=%h c=%b v=%b z=%b n=%b",
                   k, $time, ready_v[k], done_v[k], y_of(k), c_v[k], v_v[k], z_v[k], n_v[k],
                   mready[k], mdone[k], my[k], mc[k], mv[k], mz[k], mn[k]);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called just after a negedge; returns after the negedge at which done is seen.
  task automatic do_op(input int k, input logic [2:0] op, input bit dec, input logic [15:0] a,
                       input logic [15:0] b, input bit cin, output int lat);
    int n = 0;
    while (!ready_v[k] && n < 50) begin @(negedge clk); n++; end
    start_v[k] = 1'b1; op_v[k] = op; dec_v[k] = dec; a_v[k] = a; b_v[k] = b; cin_v[k] = cin;
    @(negedge clk);
    start_v[k] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done_v[k] && lat < 50);
    if (!done_v[k]) check("done_timeout", 0, 1);
  endtask

  logic [15:0] ty;
  bit          tc, tv;
  int          lat, ndone;

  initial begin
    resetn = 1'b0; start_v = '0; op_v = '0; dec_v = '0; a_v = '0; b_v = '0; cin_v = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_v[0], 1);
    check("rst_done", done_v[0], 0);
    check("rst_y", y_of(0), 0);
    check("rst_flags", {c_v[0], v_v[0], z_v[0], n_v[0]}, 0);
    resetn = 1'b1;
    @(negedge clk);

    model(8, 1'b1, 3'd1, 1'b1, 16'h12, 16'h21, 1'b1, ty, tc, tv, lat);
    check("model_dsub_y", ty, 16'h91);
    check("model_dsub_c", tc, 0);
    model(16, 1'b0, 3'd0, 1'b1, 16'h9999, 16'h0001, 1'b0, ty, tc, tv, lat);
    check("model_nodec_y", ty, 16'h999A);
    check("model_nodec_lat", lat, 1);

    do_op(0, 3'd0, 1'b0, 16'h50, 16'h50, 1'b0, lat);
    check("add_lat", lat, 1); check("add_y", y_of(0), 16'hA0); check("add_c", c_v[0], 0);
    check("add_v", v_v[0], 1); check("add_n", n_v[0], 1); check("add_z", z_v[0], 0);
    do_op(0, 3'd0, 1'b1, 16'h58, 16'h46, 1'b1, lat);
    check("dadd_lat", lat, 2); check("dadd_y", y_of(0), 16'h05);
    check("dadd_c", c_v[0], 1); check("dadd_v", v_v[0], 0);
    do_op(0, 3'd1, 1'b1, 16'h12, 16'h21, 1'b1, lat);
    check("dsub_y", y_of(0), 16'h91); check("dsub_c", c_v[0], 0); check("dsub_n", n_v[0], 1);
    do_op(0, 3'd1, 1'b0, 16'h00, 16'h01, 1'b1, lat);
    check("sub_y", y_of(0), 16'hFF); check("sub_c", c_v[0], 0);
    do_op(0, 3'd5, 1'b0, 16'h81, 16'h00, 1'b1, lat);
    check("sr_y", y_of(0), 16'hC0); check("sr_c", c_v[0], 1);
    do_op(0, 3'd6, 1'b0, 16'h81, 16'h00, 1'b0, lat);
    check("sl_y", y_of(0), 16'h02); check("sl_c", c_v[0], 1);
    do_op(0, 3'd2, 1'b0, 16'hF0, 16'h0F, 1'b0, lat);
    check("and_y", y_of(0), 16'h00); check("and_z", z_v[0], 1);
    do_op(1, 3'd0, 1'b1, 16'h9999, 16'h0001, 1'b0, lat);
    check("w16_dadd_lat", lat, 4); check("w16_dadd_y", y_of(1), 16'h0000);
    check("w16_dadd_c", c_v[1], 1); check("w16_dadd_z", z_v[1], 1);
    do_op(2, 3'd0, 1'b1, 16'h9999, 16'h0001, 1'b0, lat);
    check("nodec_lat", lat, 1); check("nodec_y", y_of(2), 16'h999A);

    // start held through decimal ops: accept, 2 DEC cycles, re-accept on the done cycle
    start_v[0] = 1'b1; op_v[0] = 3'd0; dec_v[0] = 1'b1; a_v[0] = 16'h19; b_v[0] = 16'h01; cin_v[0] = 1'b0;
    ndone = 0;
    repeat (6) begin @(negedge clk); ndone += int'(done_v[0]); end
    check("held_dec_dones", ndone, 2);
    dec_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    ndone = 0;
    repeat (6) begin @(negedge clk); ndone += int'(done_v[0]); end
    check("b2b_bin_dones", ndone, 3);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a decimal op
    start_v[0] = 1'b1; dec_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_ready", ready_v[0], 1); check("midrst_y", y_of(0), 0);
    ndone = 0;
    repeat (4) begin ndone += int'(done_v[0]); @(negedge clk); end
    check("midrst_no_done", ndone, 0);

    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 3; k++) begin
        start_v[k] = ($urandom_range(0, 2) != 0);
        op_v[k]    = 3'($urandom_range(0, 7));
        dec_v[k]   = $urandom_range(0, 1) == 1;
        a_v[k]     = 16'($urandom);
        b_v[k]     = 16'($urandom);
        cin_v[k]   = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
    end
    resetn = 1'b1; start_v = '0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
